// File: rtl/fetch_if.sv
// Bundle of signals between the fetch stage and its surroundings: control inputs,
// instruction-memory port and the IF/ID pipeline register outputs.
interface fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc;
  logic               ifid_valid;
  logic               end_flag;
  logic [CNT_W-1:0]   fetch_count;

  // Handshake: there is no valid/ready pair. ifid_valid qualifies ifid_instr/ifid_pc
  // in every cycle. stall is the only backpressure: while stall=1, pc and IF/ID hold.
  // A branch_taken redirect always wins over stall.
  modport master (
    input  start, stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, end_flag, fetch_count
  );

  modport slave (
    output start, stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, end_flag, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads IF/ID.
// Sequences start-up, stall, branch redirect and halt-drain, then raises end_flag.
module fetch_stage #(
  parameter int              ADDR_W       = 32,
  parameter int              INSTR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]      HALT_OPCODE  = 4'hF,
  parameter int              DRAIN_CYCLES = 4,
  parameter int              CNT_W        = 16
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus,
  output logic [1:0] state_dbg
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] ifid_instr, ifid_instr_n;
  logic [ADDR_W-1:0]  ifid_pc, ifid_pc_n;
  logic               ifid_valid, ifid_valid_n;
  logic               end_flag, end_flag_n;
  logic [CNT_W-1:0]   fetch_count, fetch_count_n;
  logic [DW-1:0]      drain_cnt, drain_cnt_n;
  logic [DW-1:0]      drain_inc;
  logic [CNT_W-1:0]   count_inc;
  logic               is_halt;

  assign is_halt   = (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign drain_inc = drain_cnt + 1'b1;
  assign count_inc = (fetch_count == '1) ? fetch_count : fetch_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ifid_instr  <= '0;
      ifid_pc     <= '0;
      ifid_valid  <= 1'b0;
      end_flag    <= 1'b0;
      fetch_count <= '0;
      drain_cnt   <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ifid_instr  <= ifid_instr_n;
      ifid_pc     <= ifid_pc_n;
      ifid_valid  <= ifid_valid_n;
      end_flag    <= end_flag_n;
      fetch_count <= fetch_count_n;
      drain_cnt   <= drain_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ifid_instr_n  = ifid_instr;
    ifid_pc_n     = ifid_pc;
    ifid_valid_n  = ifid_valid;
    end_flag_n    = end_flag;
    fetch_count_n = fetch_count;
    drain_cnt_n   = drain_cnt;

    case (state)
      IDLE: begin
        ifid_instr_n = '0;
        ifid_valid_n = 1'b0;
        if (bus.start) state_n = RUN;
      end

      RUN: begin
        if (bus.branch_taken) begin
          pc_n         = bus.branch_target;
          ifid_instr_n = '0;
          ifid_valid_n = 1'b0;
        end else if (!bus.stall) begin
          ifid_instr_n  = bus.imem_rdata;
          ifid_pc_n     = pc;
          ifid_valid_n  = 1'b1;
          fetch_count_n = count_inc;
          // The halt itself stays at pc so a later redirect is the only way forward.
          if (is_halt) begin
            state_n     = DRAIN;
            drain_cnt_n = '0;
          end else begin
            pc_n = pc + ADDR_W'(4);
          end
        end
      end

      DRAIN: begin
        ifid_instr_n = '0;
        ifid_valid_n = 1'b0;
        if (bus.branch_taken) begin
          // An older branch resolved late: the halt was on the wrong path.
          pc_n        = bus.branch_target;
          drain_cnt_n = '0;
          state_n     = RUN;
        end else if (!bus.stall) begin
          drain_cnt_n = drain_inc;
          if (drain_inc == DRAIN_LAST) begin
            end_flag_n = 1'b1;
            state_n    = DONE;
          end
        end
      end

      DONE: begin
        ifid_instr_n = '0;
        ifid_valid_n = 1'b0;
        end_flag_n   = 1'b1;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.imem_addr   = pc;
  assign bus.ifid_instr  = ifid_instr;
  assign bus.ifid_pc     = ifid_pc;
  assign bus.ifid_valid  = ifid_valid;
  assign bus.end_flag    = end_flag;
  assign bus.fetch_count = fetch_count;
  assign state_dbg       = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios push expected IF/ID contents into a queue,
// a negedge monitor pops and compares every newly loaded instruction.
module tb_fetch_stage;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;
  logic       stall_q = 1'b0;
  int         total = 0;
  int         bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mem [64];

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(CNT_W)) bus ();

  assign bus.imem_rdata = (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:2]] : 32'h0;

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a < 32'd256) ? mem[a[7:2]] : 32'h0;
  endfunction

  task automatic exp_push(input logic [31:0] a);
    exp_q.push_back({a, word_at(a)});
  endtask

  // Inputs change on the negedge; returns at the following negedge with results settled.
  task automatic drive(input logic st, input logic sl, input logic br, input logic [31:0] tgt);
    bus.start         = st;
    bus.stall         = sl;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"},  64'(bus.imem_addr), 64'h0);
    chk({tag, "_valid"}, 64'(bus.ifid_valid), 64'h0);
    chk({tag, "_instr"}, 64'(bus.ifid_instr), 64'h0);
    chk({tag, "_pc"},    64'(bus.ifid_pc), 64'h0);
    chk({tag, "_end"},   64'(bus.end_flag), 64'h0);
    chk({tag, "_count"}, 64'(bus.fetch_count), 64'h0);
    chk({tag, "_state"}, 64'(state_dbg), 64'h0);
  endtask

  always @(posedge clk) stall_q <= bus.stall;

  always @(negedge clk) begin
    if (bus.ifid_valid === 1'b1 && !stall_q) begin
      if (exp_q.size() == 0) chk("fetch_q_nonempty", 64'(exp_q.size()), 64'd1);
      else chk("ifid_fetch", {bus.ifid_pc, bus.ifid_instr}, exp_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0020_8033;
    mem[1]  = 32'h0031_00b3;
    mem[2]  = 32'h0041_8133;
    mem[3]  = 32'hF000_0000;
    mem[8]  = 32'h0052_01b3;
    mem[9]  = 32'h0062_8233;
    mem[10] = 32'hF000_0000;
    mem[16] = 32'h0073_02b3;
    mem[17] = 32'hF000_0000;

    // Reset and idle
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check_reset("por");
    reset = 1'b0;
    repeat (10) drive(0, 0, 0, 0);
    chk("idle_addr",  64'(bus.imem_addr), 64'h0);
    chk("idle_valid", 64'(bus.ifid_valid), 64'h0);
    chk("idle_end",   64'(bus.end_flag), 64'h0);
    chk("idle_count", 64'(bus.fetch_count), 64'h0);
    chk("idle_state", 64'(state_dbg), 64'h0);

    // Start, straight-line fetch with a 3-cycle stall at pc=8, halt and drain
    drive(1, 0, 0, 0);
    chk("start_state", 64'(state_dbg), 64'h1);
    chk("start_addr",  64'(bus.imem_addr), 64'h0);
    chk("start_valid", 64'(bus.ifid_valid), 64'h0);
    exp_push(0);  drive(0, 0, 0, 0);
    chk("run_addr4", 64'(bus.imem_addr), 64'h4);
    exp_push(4);  drive(0, 0, 0, 0);
    chk("run_addr8", 64'(bus.imem_addr), 64'h8);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      chk("stall_addr",    64'(bus.imem_addr), 64'h8);
      chk("stall_ifid_pc", 64'(bus.ifid_pc), 64'h4);
      chk("stall_valid",   64'(bus.ifid_valid), 64'h1);
    end
    exp_push(8);  drive(0, 0, 0, 0);
    chk("resume_addr", 64'(bus.imem_addr), 64'hc);
    exp_push(12); drive(0, 0, 0, 0);
    chk("halt_state", 64'(state_dbg), 64'h2);
    chk("halt_count", 64'(bus.fetch_count), 64'h4);
    chk("halt_addr",  64'(bus.imem_addr), 64'hc);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk("drain_end",   64'(bus.end_flag), 64'h0);
      chk("drain_valid", 64'(bus.ifid_valid), 64'h0);
    end
    drive(0, 0, 0, 0);
    chk("end_flag",  64'(bus.end_flag), 64'h1);
    chk("end_state", 64'(state_dbg), 64'h3);
    drive(1, 1, 1, 32'h80);
    drive(1, 0, 1, 32'h80);
    chk("done_end",   64'(bus.end_flag), 64'h1);
    chk("done_addr",  64'(bus.imem_addr), 64'hc);
    chk("done_count", 64'(bus.fetch_count), 64'h4);
    chk("done_valid", 64'(bus.ifid_valid), 64'h0);

    // Reset out of DONE
    reset = 1'b1; drive(0, 0, 0, 0); reset = 1'b0;
    check_reset("rst_done");

    // Branch with simultaneous stall, then a branch that squashes a wrong-path halt
    drive(1, 0, 0, 0);
    exp_push(0); drive(0, 0, 0, 0);
    exp_push(4); drive(0, 0, 0, 0);
    drive(0, 1, 1, 32'h40);
    chk("br_stall_addr",  64'(bus.imem_addr), 64'h40);
    chk("br_stall_valid", 64'(bus.ifid_valid), 64'h0);
    chk("br_stall_count", 64'(bus.fetch_count), 64'h2);
    exp_push(32'h40); drive(0, 0, 0, 0);
    exp_push(32'h44); drive(0, 0, 0, 0);
    chk("halt2_state", 64'(state_dbg), 64'h2);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 32'h20);
    chk("squash_state", 64'(state_dbg), 64'h1);
    chk("squash_addr",  64'(bus.imem_addr), 64'h20);
    chk("squash_end",   64'(bus.end_flag), 64'h0);
    chk("squash_valid", 64'(bus.ifid_valid), 64'h0);
    exp_push(32'h20); drive(0, 0, 0, 0);
    exp_push(32'h24); drive(0, 0, 0, 0);
    exp_push(32'h28); drive(0, 0, 0, 0);
    chk("halt3_state", 64'(state_dbg), 64'h2);
    chk("halt3_count", 64'(bus.fetch_count), 64'h7);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk("drain_stall_end",   64'(bus.end_flag), 64'h0);
    chk("drain_stall_state", 64'(state_dbg), 64'h2);
    drive(0, 0, 0, 0);
    chk("drain_stall_end2", 64'(bus.end_flag), 64'h1);

    // Reset out of DRAIN, then re-run from pc=0
    reset = 1'b1; drive(0, 0, 0, 0); reset = 1'b0;
    check_reset("rst_done2");
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_push(32'(4 * i));
      drive(0, 0, 0, 0);
    end
    chk("rerun_drain_state", 64'(state_dbg), 64'h2);
    drive(0, 0, 0, 0);
    reset = 1'b1; drive(0, 0, 0, 0); reset = 1'b0;
    check_reset("rst_drain");
    drive(1, 0, 0, 0);
    exp_push(0); drive(0, 0, 0, 0);
    chk("rerun_addr",  64'(bus.imem_addr), 64'h4);
    chk("rerun_count", 64'(bus.fetch_count), 64'h1);

    // PC wrap at the top of the address space, then fetch_count saturation
    drive(0, 0, 1, 32'hFFFF_FFF0);
    for (int i = 0; i < 4; i++) begin
      exp_push(32'hFFFF_FFF0 + 32'(4 * i));
      drive(0, 0, 0, 0);
    end
    chk("wrap_addr",  64'(bus.imem_addr), 64'h0);
    chk("wrap_count", 64'(bus.fetch_count), 64'h5);
    drive(0, 0, 1, 32'h100);
    for (int i = 0; i < 10; i++) begin
      exp_push(32'h100 + 32'(4 * i));
      drive(0, 0, 0, 0);
    end
    chk("count_full", 64'(bus.fetch_count), 64'hf);
    for (int i = 10; i < 13; i++) begin
      exp_push(32'h100 + 32'(4 * i));
      drive(0, 0, 0, 0);
    end
    chk("count_sat", 64'(bus.fetch_count), 64'hf);
    chk("sat_addr",  64'(bus.imem_addr), 64'h134);

    reset = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
